// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader_pkg
// Purpose  : Shared constants for the UART boot loader: FSM state codes and
//            the default acknowledge byte.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_HDR  = 3'd1;
  localparam state_t S_ACK  = 3'd2;
  localparam state_t S_DATA = 3'd3;
  localparam state_t S_DONE = 3'd4;
  localparam state_t S_FIN  = 3'd5;
  localparam state_t S_ERR  = 3'd6;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/uart_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_assembler
// Purpose  : Packs a little-endian byte stream into 32-bit words and watches
//            for stalls in the middle of a word.
// Ports    : clk, rstn        clock / async active-low reset
//            clear_i          hold byte index and timeout counter at 0
//            byte_valid_i     accept byte_i this cycle
//            byte_i[7:0]      incoming byte (first byte -> bits [7:0])
//            word_o[31:0]     assembled word, valid with word_valid_o
//            word_valid_o     1-cycle pulse the cycle after the 4th byte
//            timeout_o        word partially received and no byte for
//                             TIMEOUT_CYCLES cycles
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_assembler
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        timeout_o
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; the timeout fires on the
  // idle cycle that would take it to TIMEOUT_CYCLES.
  localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]      idx_q;
  logic [31:0]     word_q;
  logic            word_valid_q;
  logic [c_CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q        <= 2'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear_i) begin
        idx_q <= 2'd0;
        cnt_q <= '0;
      end else if (byte_valid_i) begin
        word_q[{idx_q, 3'b000} +: 8] <= byte_i;
        idx_q        <= idx_q + 2'd1;       // wraps 3 -> 0
        word_valid_q <= (idx_q == 2'd3);
        cnt_q        <= '0;
      end else if (idx_q != 2'd0) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign timeout_o    = !clear_i && !byte_valid_i && (idx_q != 2'd0) &&
                        (cnt_q == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_loader
// Purpose  : Boot-time program loader. Receives a word count N and N program
//            words over UART, acknowledges the header, writes the words to
//            instruction memory and then releases the CPU.
// Ports    : clk, rstn            clock / async active-low reset
//            enable               start loading (level)
//            rx_data/valid/ferr   byte stream from the UART receiver
//            tx_data/valid/ready  acknowledge byte towards the UART sender
//            mem_we/addr/wdata    instruction-memory write port
//            cpu_start            sticky, set after a complete load
//            done                 1-cycle pulse when the load completes
//            err                  sticky, set on any load error
// Revision : 1.0 - initial release
// ============================================================================
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 14,
  parameter int         BASE_ADDR      = 0,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_ferr,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_start,
  output logic                  done,
  output logic                  err
);

  // Largest legal word count: words from BASE_ADDR up to the top of memory.
  // Held in 33 bits so the comparison against a 32-bit N cannot overflow.
  localparam logic [32:0] c_LIMIT =
    33'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));

  state_t                state_q, state_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           k_q, k_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  pend_q, pend_d;
  logic [31:0]           pend_word_q, pend_word_d;
  logic                  cpu_start_q, cpu_start_d;
  logic                  err_q, err_d;

  logic        w_active;
  logic        w_fail;
  logic        w_byte_valid;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic        w_timeout;
  logic        w_do_write;
  logic [31:0] w_wr_word;

  assign w_active = (state_q == S_HDR) || (state_q == S_ACK) ||
                    (state_q == S_DATA);
  // A byte that arrives together with a framing error is dropped.
  assign w_byte_valid = rx_valid && !rx_ferr;
  assign w_fail       = w_active && (rx_ferr || w_timeout);

  byte_word_assembler #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .clear_i      (!w_active),
    .byte_valid_i (w_byte_valid),
    .byte_i       (rx_data),
    .word_o       (w_word),
    .word_valid_o (w_word_valid),
    .timeout_o    (w_timeout)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    cpu_start_d = cpu_start_q;
    err_d       = err_q;
    w_do_write  = 1'b0;
    w_wr_word   = w_word;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_HDR;
      end
      S_HDR: begin
        if (w_word_valid) begin
          n_d     = w_word;
          state_d = ({1'b0, w_word} > c_LIMIT) ? S_ERR : S_ACK;
        end
      end
      S_ACK: begin
        // A word finishing while the ack is stalled is parked until the
        // ack goes out; only the first such word is kept.
        if (w_word_valid && !pend_q) begin
          pend_d      = 1'b1;
          pend_word_d = w_word;
        end
        if (tx_ready) begin
          pend_d = 1'b0;
          if (n_q == 32'd0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_DATA;
            w_do_write = pend_q || w_word_valid;
            w_wr_word  = pend_q ? pend_word_q : w_word;
          end
        end
      end
      S_DATA: begin
        w_do_write = w_word_valid;
      end
      S_DONE: begin
        cpu_start_d = 1'b1;
        state_d     = S_FIN;
      end
      default: begin
        // S_FIN and S_ERR are terminal until reset.
      end
    endcase

    if (w_do_write && !w_fail) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ADDR_WIDTH'(32'(BASE_ADDR) + k_q);
      mem_wdata_d = w_wr_word;
      k_d         = k_q + 32'd1;
      if ((k_q + 32'd1) == n_q) state_d = S_DONE;
    end

    if (w_fail) state_d = S_ERR;
    if (state_d == S_ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      n_q         <= 32'd0;
      k_q         <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      pend_q      <= 1'b0;
      pend_word_q <= 32'd0;
      cpu_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      cpu_start_q <= cpu_start_d;
      err_q       <= err_d;
    end
  end

  assign tx_data   = ACK_BYTE;
  assign tx_valid  = (state_q == S_ACK);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_start = cpu_start_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_loader
// Purpose  : Self-checking bench for uart_loader. Expected memory writes are
//            derived from the words the bench sends: word i of a load goes
//            to address BASE+i, a header above the memory limit or a stream
//            error yields no further writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

  localparam int         AW    = 5;
  localparam int         BASE  = 3;
  localparam int         TO    = 40;
  localparam int         LIMIT = (1 << AW) - BASE;   // 29 words fit
  localparam logic [7:0] ACK   = 8'hAA;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ferr = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_start;
  logic          done;
  logic          err;

  uart_loader #(
    .ADDR_WIDTH     (AW),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TO),
    .ACK_BYTE       (ACK)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_start (cpu_start),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Monitor state, owned by the negedge process only.
  int            cyc = 0;
  int            done_cnt = 0, ack_cnt = 0, txv_cnt = 0;
  int            done_cyc = 0, ack_cyc = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            wc_q[$];
  int            lb_q[$];
  logic          tb_last = 1'b0;

  // Snapshots taken at each reset so tests look only at their own events.
  int w0, d0, a0, t0, l0;
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wc_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (tx_valid === 1'b1) begin
      txv_cnt = txv_cnt + 1;
      if (tx_ready) begin
        ack_cnt = ack_cnt + 1;
        ack_cyc = cyc;
      end
    end
    if (rx_valid && !rx_ferr && tb_last) lb_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0;
    rx_data = 8'h00; tx_ready = 1'b1; tb_last = 1'b0;
    repeat (3) tick();
    w0 = wa_q.size(); d0 = done_cnt; a0 = ack_cnt; t0 = txv_cnt; l0 = lb_q.size();
    rstn = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic last);
    repeat (gap) tick();
    rx_data = b; rx_valid = 1'b1; tb_last = last;
    tick();
    rx_valid = 1'b0; tb_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax, input logic data_word);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], int'($urandom_range(gmax)), data_word && (i == 3));
  endtask

  task automatic start_load(input logic [31:0] n, input logic rdy);
    do_reset();
    tx_ready = rdy;
    enable = 1'b1;
    tick();
    send_word(n, 0, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((done_cnt == d0) && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  task automatic fill_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back($urandom);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    repeat (2) tick();
    total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we); else passed++;
    total++; if (mem_addr !== '0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'd0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else passed++;
    total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", tx_valid); else passed++;
    total++; if (tx_data !== ACK) $display("FAIL rst_tx_data: got %h want %h", tx_data, ACK); else passed++;
    total++; if ({done, cpu_start, err} !== 3'b000)
      $display("FAIL rst_flags: got %b want 000", {done, cpu_start, err}); else passed++;
    // Out of reset with enable low: bytes and framing errors are ignored.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0, 1'b0);
    rx_ferr = 1'b1; tick(); rx_ferr = 1'b0;
    repeat (3) tick();
    total++; if (err !== 1'b0) $display("FAIL idle_err: got %b want 0", err); else passed++;
    total++; if (txv_cnt - t0 !== 0) $display("FAIL idle_tx: got %0d want 0", txv_cnt - t0); else passed++;
  endtask

  task automatic test_basic();
    exp_q.delete();
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'hDEADBEEF);
    start_load(32'd2, 1'b1);
    foreach (exp_q[i]) send_word(exp_q[i], 2, 1'b1);
    wait_done(40);
    repeat (3) tick();
    total++; if (ack_cnt - a0 !== 1) $display("FAIL basic_ack: got %0d want 1", ack_cnt - a0); else passed++;
    total++; if (wa_q.size() - w0 !== 2) $display("FAIL basic_nwr: got %0d want 2", wa_q.size() - w0); else passed++;
    for (int i = 0; i < 2 && (w0 + i) < wa_q.size(); i++) begin
      total++;
      if (wa_q[w0+i] !== AW'(BASE + i) || wd_q[w0+i] !== exp_q[i])
        $display("FAIL basic_wr%0d: got %h@%h want %h@%h", i, wd_q[w0+i], wa_q[w0+i], exp_q[i], AW'(BASE + i));
      else passed++;
      total++;
      if (wc_q[w0+i] - lb_q[l0+i] !== 2)
        $display("FAIL basic_lat%0d: got %0d want 2", i, wc_q[w0+i] - lb_q[l0+i]);
      else passed++;
    end
    total++; if (done_cnt - d0 !== 1) $display("FAIL basic_done: got %0d want 1", done_cnt - d0); else passed++;
    total++; if ({cpu_start, err} !== 2'b10) $display("FAIL basic_flags: got %b want 10", {cpu_start, err}); else passed++;
    // After the load completes further bytes must not be written.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0, 1'b0);
    repeat (4) tick();
    total++; if (wa_q.size() - w0 !== 2) $display("FAIL basic_fin: got %0d want 2", wa_q.size() - w0); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(8, 3));
      fill_exp(n);
      start_load(32'(n), 1'b1);
      foreach (exp_q[i]) send_word(exp_q[i], 0, 1'b1);
      wait_done(20);
      repeat (2) tick();
      total++;
      if (wa_q.size() - w0 !== n) $display("FAIL b2b_nwr: got %0d want %0d", wa_q.size() - w0, n);
      else passed++;
      for (int i = 0; i < n && (w0 + i) < wa_q.size(); i++) begin
        total++;
        if (wa_q[w0+i] !== AW'(BASE + i) || wd_q[w0+i] !== exp_q[i])
          $display("FAIL b2b_wr%0d: got %h@%h want %h@%h", i, wd_q[w0+i], wa_q[w0+i], exp_q[i], AW'(BASE + i));
        else passed++;
      end
      total++;
      if ({done_cnt - d0 == 1, cpu_start, err} !== 3'b110)
        $display("FAIL b2b_end: got done=%0d cpu=%b err=%b", done_cnt - d0, cpu_start, err);
      else passed++;
    end
  endtask

  task automatic test_zero();
    start_load(32'd0, 1'b1);
    wait_done(20);
    tick();
    total++; if (ack_cnt - a0 !== 1) $display("FAIL zero_ack: got %0d want 1", ack_cnt - a0); else passed++;
    total++; if (wa_q.size() - w0 !== 0) $display("FAIL zero_nwr: got %0d want 0", wa_q.size() - w0); else passed++;
    total++; if (done_cyc - ack_cyc !== 1) $display("FAIL zero_done_lat: got %0d want 1", done_cyc - ack_cyc); else passed++;
    total++; if ({cpu_start, err} !== 2'b10) $display("FAIL zero_flags: got %b want 10", {cpu_start, err}); else passed++;
  endtask

  task automatic test_ferr();
    int k;
    fill_exp(1);
    start_load(32'd3, 1'b1);
    send_word(exp_q[0], 1, 1'b1);
    repeat (3) tick();
    k = int'($urandom_range(3));
    for (int i = 0; i < k; i++) send_byte(8'($urandom), 0, 1'b0);
    rx_ferr = 1'b1; rx_valid = 1'($urandom); rx_data = 8'($urandom);
    tick();
    rx_ferr = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < 12 - k; i++) send_byte(8'($urandom), 0, 1'b0);
    repeat (5) tick();
    total++; if (err !== 1'b1) $display("FAIL ferr_err: got %b want 1", err); else passed++;
    total++; if (wa_q.size() - w0 !== 1) $display("FAIL ferr_nwr: got %0d want 1", wa_q.size() - w0); else passed++;
    if (wa_q.size() > w0) begin
      total++;
      if (wa_q[w0] !== AW'(BASE) || wd_q[w0] !== exp_q[0])
        $display("FAIL ferr_wr: got %h@%h want %h@%h", wd_q[w0], wa_q[w0], exp_q[0], AW'(BASE));
      else passed++;
    end
    total++; if ({cpu_start, done_cnt - d0 == 0} !== 2'b01)
      $display("FAIL ferr_nostart: cpu=%b done=%0d want 0/0", cpu_start, done_cnt - d0); else passed++;
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    start_load(32'd1, 1'b1);
    send_byte(8'($urandom), 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    repeat (TO + 1) tick();
    total++; if (err !== 1'b1) $display("FAIL tmo_err: got %b want 1", err); else passed++;
    send_byte(8'($urandom), 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    repeat (4) tick();
    total++; if (wa_q.size() - w0 !== 0) $display("FAIL tmo_nwr: got %0d want 0", wa_q.size() - w0); else passed++;
    total++; if (cpu_start !== 1'b0) $display("FAIL tmo_cpu: got %b want 0", cpu_start); else passed++;
    // Long idle with no partial word, then gaps just under the limit.
    w = $urandom;
    start_load(32'd1, 1'b1);
    repeat (2 * TO) tick();
    send_byte(w[7:0], 0, 1'b0);
    send_byte(w[15:8], 0, 1'b0);
    send_byte(w[23:16], TO - 1, 1'b0);
    send_byte(w[31:24], TO - 1, 1'b1);
    wait_done(10);
    tick();
    total++; if (err !== 1'b0) $display("FAIL tmo_gap_err: got %b want 0", err); else passed++;
    total++;
    if (wa_q.size() - w0 !== 1 || wd_q[w0] !== w)
      $display("FAIL tmo_gap_wr: got n=%0d data=%h want 1/%h", wa_q.size() - w0, wd_q[w0], w);
    else passed++;
    total++; if (cpu_start !== 1'b1) $display("FAIL tmo_gap_cpu: got %b want 1", cpu_start); else passed++;
  endtask

  task automatic test_limit();
    for (int r = 0; r < 3; r++) begin
      logic [31:0] n;
      n = (r == 0) ? 32'(LIMIT + 1) : (r == 1) ? 32'((1 << AW) + 1) : {1'b1, 31'($urandom)};
      start_load(n, 1'b1);
      send_word($urandom, 0, 1'b1);
      repeat (4) tick();
      total++;
      if ({err, txv_cnt - t0 == 0, wa_q.size() - w0 == 0} !== 3'b111)
        $display("FAIL limit_rej n=%h: err=%b tx=%0d wr=%0d want 1/0/0", n, err, txv_cnt - t0, wa_q.size() - w0);
      else passed++;
    end
    fill_exp(LIMIT);
    start_load(32'(LIMIT), 1'b1);
    foreach (exp_q[i]) send_word(exp_q[i], 0, 1'b1);
    wait_done(20);
    tick();
    total++;
    if (wa_q.size() - w0 !== LIMIT) $display("FAIL limit_nwr: got %0d want %0d", wa_q.size() - w0, LIMIT);
    else passed++;
    for (int i = 0; i < LIMIT && (w0 + i) < wa_q.size(); i++) begin
      total++;
      if (wa_q[w0+i] !== AW'(BASE + i) || wd_q[w0+i] !== exp_q[i])
        $display("FAIL limit_wr%0d: got %h@%h want %h@%h", i, wd_q[w0+i], wa_q[w0+i], exp_q[i], AW'(BASE + i));
      else passed++;
    end
    total++; if ({cpu_start, err} !== 2'b10) $display("FAIL limit_flags: got %b want 10", {cpu_start, err}); else passed++;
  endtask

  task automatic test_backpressure();
    fill_exp(2);
    start_load(32'd2, 1'b0);
    send_word(exp_q[0], 0, 1'b1);
    repeat (90) tick();
    total++;
    if ({tx_valid, ack_cnt - a0 == 0, wa_q.size() - w0 == 0} !== 3'b111)
      $display("FAIL bp_hold: tx_valid=%b ack=%0d wr=%0d want 1/0/0", tx_valid, ack_cnt - a0, wa_q.size() - w0);
    else passed++;
    tx_ready = 1'b1;
    repeat (4) tick();
    total++;
    if (wa_q.size() - w0 !== 1 || wa_q[w0] !== AW'(BASE) || wd_q[w0] !== exp_q[0])
      $display("FAIL bp_wr0: got n=%0d %h@%h want 1 %h@%h", wa_q.size() - w0, wd_q[w0], wa_q[w0], exp_q[0], AW'(BASE));
    else passed++;
    total++; if (wc_q[w0] - ack_cyc !== 1) $display("FAIL bp_lat: got %0d want 1", wc_q[w0] - ack_cyc); else passed++;
    send_word(exp_q[1], 1, 1'b1);
    wait_done(20);
    tick();
    total++;
    if (wa_q.size() - w0 !== 2 || wa_q[w0+1] !== AW'(BASE + 1) || wd_q[w0+1] !== exp_q[1] || cpu_start !== 1'b1)
      $display("FAIL bp_wr1: got n=%0d %h@%h cpu=%b want 2 %h@%h 1", wa_q.size() - w0, wd_q[w0+1],
               wa_q[w0+1], cpu_start, exp_q[1], AW'(BASE + 1));
    else passed++;
  endtask

  task automatic test_ack_collision();
    fill_exp(2);
    start_load(32'd2, 1'b0);
    send_word(exp_q[0], 0, 1'b1);
    // Word completes this cycle's edge; release the ack on the same edge.
    tx_ready = 1'b1;
    repeat (3) tick();
    total++;
    if (wa_q.size() - w0 !== 1 || wd_q[w0] !== exp_q[0] || wa_q[w0] !== AW'(BASE))
      $display("FAIL coll_wr: got n=%0d %h@%h want 1 %h@%h", wa_q.size() - w0, wd_q[w0], wa_q[w0], exp_q[0], AW'(BASE));
    else passed++;
    total++; if (wc_q[w0] - ack_cyc !== 1) $display("FAIL coll_lat: got %0d want 1", wc_q[w0] - ack_cyc); else passed++;
  endtask

  task automatic test_reset_midload();
    int n;
    fill_exp(1);
    start_load(32'd2, 1'b1);
    send_word(exp_q[0], 0, 1'b1);
    repeat (3) tick();
    send_byte(8'($urandom), 0, 1'b0);
    send_byte(8'($urandom), 0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({mem_we, tx_valid, done, cpu_start, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== 32'd0)
      $display("FAIL midrst_outs: got we=%b tv=%b d=%b c=%b e=%b a=%h wd=%h want all 0",
               mem_we, tx_valid, done, cpu_start, err, mem_addr, mem_wdata);
    else passed++;
    n = int'($urandom_range(5, 2));
    fill_exp(n);
    start_load(32'(n), 1'b1);
    foreach (exp_q[i]) send_word(exp_q[i], 1, 1'b1);
    wait_done(40);
    tick();
    total++;
    if (wa_q.size() - w0 !== n) $display("FAIL reload_nwr: got %0d want %0d", wa_q.size() - w0, n);
    else passed++;
    for (int i = 0; i < n && (w0 + i) < wa_q.size(); i++) begin
      total++;
      if (wa_q[w0+i] !== AW'(BASE + i) || wd_q[w0+i] !== exp_q[i])
        $display("FAIL reload_wr%0d: got %h@%h want %h@%h", i, wd_q[w0+i], wa_q[w0+i], exp_q[i], AW'(BASE + i));
      else passed++;
    end
    total++; if ({cpu_start, err} !== 2'b10) $display("FAIL reload_flags: got %b want 10", {cpu_start, err}); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_ferr();
    test_timeout();
    test_limit();
    test_backpressure();
    test_ack_collision();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
